// File: rtl/vector_compare_mask_packer_pkg.sv
// Shared types for the vector compare mask packer: SEW encoding, packer states, default sizes.
// MAX_VLEN sets the default vector register width (128 when not supplied).
`ifndef MAX_VLEN
`define MAX_VLEN 128
`endif

package vector_compare_mask_packer_pkg;

    typedef enum logic [1:0] {
        SEW_8  = 2'b00,
        SEW_16 = 2'b01,
        SEW_32 = 2'b10,
        SEW_64 = 2'b11
    } sew_e;

    typedef enum logic [0:0] {
        PK_ACCUM = 1'b0,
        PK_OUT   = 1'b1
    } pack_state_e;

    localparam int VLEN_DEF      = `MAX_VLEN;
    localparam int MAX_BEATS_DEF = 8;

endpackage

// File: rtl/vector_compare_mask_packer_if.sv
// Beat input, control sampling and mask writeback bundle between compare unit, packer and writeback.
interface vector_compare_mask_packer_if #(
    parameter int VLEN = vector_compare_mask_packer_pkg::VLEN_DEF
) ();
    localparam int VW = $clog2(VLEN) + 1;

    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [VLEN-1:0] compare_result;
    logic [1:0]      sew;
    logic [VW-1:0]   vl;
    logic [VW-1:0]   vstart;
    logic            vm;
    logic [VLEN-1:0] v0_mask;
    logic [VLEN-1:0] vd_old;
    logic            out_valid;
    logic            out_ready;
    logic [VLEN-1:0] mask_out;
    logic            err;

    modport master (
        output in_valid, in_last, compare_result, sew, vl, vstart, vm, v0_mask, vd_old, out_ready,
        input  in_ready, out_valid, mask_out, err
    );

    modport slave (
        input  in_valid, in_last, compare_result, sew, vl, vstart, vm, v0_mask, vd_old, out_ready,
        output in_ready, out_valid, mask_out, err
    );
endinterface

// File: rtl/vector_compare_mask_packer_lane_extract.sv
// Pulls the LSB of every SEW-wide compare lane into a dense vector and reports the lane count.
module vector_mask_lane_extract
    import vector_compare_mask_packer_pkg::*;
#(
    parameter int VLEN = VLEN_DEF
) (
    input  logic [VLEN-1:0]          compare_result,
    input  logic [1:0]               sew,
    output logic [VLEN/8-1:0]        lanes,
    output logic [$clog2(VLEN/8):0]  elem_count
);
    localparam int CW = $clog2(VLEN/8) + 1;

    // Only lane LSBs matter; the reduction keeps the remaining bits visibly consumed.
    logic w_unused_bits;
    assign w_unused_bits = ^compare_result;

    always_comb begin
        lanes      = '0;
        elem_count = '0;
        case (sew_e'(sew))
            SEW_8: begin
                for (int i = 0; i < VLEN/8; i++) lanes[i] = compare_result[i*8];
                elem_count = CW'(VLEN/8);
            end
            SEW_16: begin
                for (int i = 0; i < VLEN/16; i++) lanes[i] = compare_result[i*16];
                elem_count = CW'(VLEN/16);
            end
            SEW_32: begin
                for (int i = 0; i < VLEN/32; i++) lanes[i] = compare_result[i*32];
                elem_count = CW'(VLEN/32);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/vector_compare_mask_packer.sv
// Packs compare beats of an LMUL group into one mask word, merges vstart/vm/vl against vd_old.
// VMASK_TAIL_AGNOSTIC_ONES_EN: tail elements are written as 1 instead of kept from vd_old.
//
// state    | meaning
// ST_ACCUM | accepting compare beats into the packed accumulator
// ST_OUT   | holding mask_out until the writeback handshake
module vector_compare_mask_packer
    import vector_compare_mask_packer_pkg::*;
#(
    parameter int VLEN      = VLEN_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input logic                         clk,
    input logic                         reset_n,
    vector_compare_mask_packer_if.slave bus
);
    localparam int VW = $clog2(VLEN) + 1;
    localparam int NL = VLEN / 8;
    localparam int CW = $clog2(NL) + 1;
    localparam int BW = $clog2(MAX_BEATS);

    localparam logic [0:0] ST_ACCUM = PK_ACCUM;
    localparam logic [0:0] ST_OUT   = PK_OUT;

    logic [0:0]      r_state;
    logic [BW-1:0]   r_beat;
    logic [VLEN-1:0] r_packed;
    logic [VLEN-1:0] r_mask_out;
    logic            r_out_valid;
    logic            r_err;

    logic [NL-1:0]   w_lanes;
    logic [CW-1:0]   w_count;
    logic [VW-1:0]   w_shift;
    logic [VLEN-1:0] w_packed_next;
    logic [VW-1:0]   w_vl_c;
    logic [VLEN-1:0] w_merged;
    logic            w_accept;
    logic            w_overflow;
    logic            w_last;
    logic            w_bad_sew;

    vector_mask_lane_extract #(.VLEN(VLEN)) u_extract (
        .compare_result (bus.compare_result),
        .sew            (bus.sew),
        .lanes          (w_lanes),
        .elem_count     (w_count)
    );

    assign w_accept      = bus.in_valid && (r_state == ST_ACCUM);
    assign w_overflow    = (r_beat == BW'(MAX_BEATS - 1)) && !bus.in_last;
    assign w_last        = bus.in_last || (r_beat == BW'(MAX_BEATS - 1));
    assign w_bad_sew     = (bus.sew == SEW_64);
    assign w_shift       = VW'(r_beat) * VW'(w_count);
    // Accumulator is zero at group start, so OR-ing in the shifted lanes places the beat.
    assign w_packed_next = r_packed | (VLEN'(w_lanes) << w_shift);
    assign w_vl_c        = (bus.vl > VW'(VLEN)) ? VW'(VLEN) : bus.vl;

    always_comb begin
        w_merged = '0;
        for (int e = 0; e < VLEN; e++) begin
            if (VW'(e) >= w_vl_c) begin
`ifdef VMASK_TAIL_AGNOSTIC_ONES_EN
                w_merged[e] = 1'b1;
`else
                w_merged[e] = bus.vd_old[e];
`endif
            end else if (VW'(e) < bus.vstart) begin
                w_merged[e] = bus.vd_old[e];
            end else if (bus.vm || bus.v0_mask[e]) begin
                w_merged[e] = w_packed_next[e];
            end else begin
                w_merged[e] = bus.vd_old[e];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_ACCUM;
            r_beat      <= '0;
            r_packed    <= '0;
            r_mask_out  <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_bad_sew || w_overflow) r_err <= 1'b1;
                        if (w_last) begin
                            r_mask_out  <= w_merged;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_OUT;
                            r_beat      <= '0;
                            r_packed    <= '0;
                        end else begin
                            r_packed <= w_packed_next;
                            r_beat   <= r_beat + 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_ACCUM;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_ACCUM);
    assign bus.out_valid = r_out_valid;
    assign bus.mask_out  = r_mask_out;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_vector_compare_mask_packer.sv
// Directed bench for vector_compare_mask_packer at VLEN=128; honours VMASK_TAIL_AGNOSTIC_ONES_EN.
module tb_vector_compare_mask_packer;
    localparam int VLEN = 128;
    localparam logic [127:0] ONES = '1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vector_compare_mask_packer_if #(.VLEN(VLEN)) bus ();

    vector_compare_mask_packer #(.VLEN(VLEN), .MAX_BEATS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane LSBs from pat; the other lane bits carry junk that must be ignored.
    function automatic logic [127:0] mk_cr(input logic [1:0] s, input logic [15:0] pat);
        logic [127:0] c;
        c = {4{32'hFEFE_FEFE}};
        case (s)
            2'b00:   for (int i = 0; i < 16; i++) c[i*8]  = pat[i];
            2'b01:   for (int i = 0; i < 8; i++)  c[i*16] = pat[i];
            2'b10:   for (int i = 0; i < 4; i++)  c[i*32] = pat[i];
            default: c = ONES;
        endcase
        return c;
    endfunction

    function automatic logic [127:0] tail(input logic [127:0] m, input logic [127:0] vd, input int vlc);
        logic [127:0] r;
        r = m;
        for (int e = vlc; e < 128; e++) begin
`ifdef VMASK_TAIL_AGNOSTIC_ONES_EN
            r[e] = 1'b1;
`else
            r[e] = vd[e];
`endif
        end
        return r;
    endfunction

    task automatic set_ctl(input logic [7:0] vl, input logic [7:0] vs, input logic vm,
                           input logic [127:0] v0, input logic [127:0] vd);
        bus.vl = vl; bus.vstart = vs; bus.vm = vm; bus.v0_mask = v0; bus.vd_old = vd;
    endtask

    task automatic beat(input logic [1:0] s, input logic [15:0] pat, input logic last);
        bus.in_valid = 1'b1;
        bus.sew = s;
        bus.compare_result = mk_cr(s, pat);
        bus.in_last = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    logic [127:0] exp_m;
    logic [15:0]  pats [8];

    initial begin
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.compare_result = '0; bus.sew = 2'b00;
        bus.out_ready = 1'b0;
        set_ctl(8'd0, 8'd0, 1'b1, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_mask_out", bus.mask_out, '0);
        check("rst_err", bus.err, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // single sew=8 beat
        set_ctl(8'd16, 8'd0, 1'b1, '0, '0);
        beat(2'b00, 16'hA5C3, 1'b1);
        check("t1_out_valid", bus.out_valid, 1'b1);
        check("t1_mask", bus.mask_out, tail({112'b0, 16'hA5C3}, '0, 16));
        check("t1_in_ready_out", bus.in_ready, 1'b0);
        drain();
        check("t1_out_valid_fall", bus.out_valid, 1'b0);
        check("t1_in_ready_back", bus.in_ready, 1'b1);

        // four sew=32 beats, vl=13 over all-ones vd_old
        set_ctl(8'd13, 8'd0, 1'b1, '0, ONES);
        beat(2'b10, 16'h000B, 1'b0);
        beat(2'b10, 16'h0001, 1'b0);
        beat(2'b10, 16'h000F, 1'b0);
        check("t2_no_early_valid", bus.out_valid, 1'b0);
        beat(2'b10, 16'h0004, 1'b1);
        check("t2_out_valid", bus.out_valid, 1'b1);
        check("t2_mask", bus.mask_out, tail({112'b0, 16'hEF1B}, ONES, 13));
        drain();

        // v0 masking, mask-undisturbed
        set_ctl(8'd16, 8'd0, 1'b0, {112'b0, 16'h00FF}, '0);
        beat(2'b00, 16'hFFFF, 1'b1);
        check("t3_mask_v0", bus.mask_out, tail({112'b0, 16'h00FF}, '0, 16));
        drain();

        // vstart prefix
        set_ctl(8'd8, 8'd4, 1'b1, '0, '0);
        beat(2'b00, 16'hFFFF, 1'b1);
        check("t4_mask_vstart", bus.mask_out, tail({120'b0, 8'hF0}, '0, 8));
        drain();

        // backpressure: output held, stray beat refused
        set_ctl(8'd16, 8'd0, 1'b1, '0, '0);
        beat(2'b00, 16'h1234, 1'b1);
        exp_m = tail({112'b0, 16'h1234}, '0, 16);
        check("t5_mask", bus.mask_out, exp_m);
        bus.in_valid = 1'b1; bus.in_last = 1'b0; bus.sew = 2'b00;
        bus.compare_result = mk_cr(2'b00, 16'hFFFF);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("t5_hold_mask", bus.mask_out, exp_m);
            check("t5_hold_in_ready", bus.in_ready, 1'b0);
            check("t5_hold_valid", bus.out_valid, 1'b1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        check("t5_valid_fall", bus.out_valid, 1'b0);
        check("t5_in_ready_back", bus.in_ready, 1'b1);
        beat(2'b00, 16'h0F0F, 1'b1);
        check("t5_next_group", bus.mask_out, tail({112'b0, 16'h0F0F}, '0, 16));
        check("t5_err_clear", bus.err, 1'b0);
        drain();

        // eight beats with no in_last
        pats = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        set_ctl(8'd128, 8'd0, 1'b1, '0, '0);
        exp_m = '0;
        for (int k = 0; k < 8; k++) begin
            exp_m[k*16 +: 16] = pats[k];
            if (k == 7) check("ovf_no_early_valid", bus.out_valid, 1'b0);
            beat(2'b00, pats[k], 1'b0);
        end
        check("ovf_out_valid", bus.out_valid, 1'b1);
        check("ovf_mask", bus.mask_out, exp_m);
        check("ovf_err", bus.err, 1'b1);
        drain();

        // reset mid-group
        set_ctl(8'd16, 8'd0, 1'b1, '0, '0);
        beat(2'b10, 16'h000F, 1'b0);
        beat(2'b10, 16'h000F, 1'b0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_out_valid", bus.out_valid, 1'b0);
        check("rst_mid_err", bus.err, 1'b0);
        check("rst_mid_mask", bus.mask_out, '0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_in_ready", bus.in_ready, 1'b1);
        beat(2'b10, 16'h000B, 1'b0);
        beat(2'b10, 16'h0001, 1'b0);
        beat(2'b10, 16'h000F, 1'b0);
        beat(2'b10, 16'h0004, 1'b1);
        check("rst_mid_regroup", bus.mask_out, tail({112'b0, 16'h4F1B}, '0, 16));
        check("rst_mid_err_still0", bus.err, 1'b0);
        drain();

        // unsupported sew
        set_ctl(8'd16, 8'd0, 1'b1, '0, '0);
        beat(2'b11, 16'hFFFF, 1'b1);
        check("sew64_out_valid", bus.out_valid, 1'b1);
        check("sew64_mask", bus.mask_out, tail('0, '0, 16));
        check("sew64_err", bus.err, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
